// File: rtl/block_nconv_sequencer.sv
// Control sequencer for one VGG16 conv block: 1..4 chained 3x3 conv layers,
// then an optional 2x2 max-pool. Walks layer -> kernel -> channel and issues
// one conv-engine job per (kernel, channel) pair, then optionally one pool
// job, then pulses o_valid. Every output is a register.
module block_nconv_sequencer #(
  parameter int NUM_LAYERS        = 2,
  parameter int IMAGE_WIDTH       = 56,
  parameter int NUMBER_OF_KERNEL  = 16,
  parameter int NUMBER_OF_CHANNEL = 8,
  parameter int POOL_EN           = 1,
  localparam int MAX_CK = (NUMBER_OF_CHANNEL > NUMBER_OF_KERNEL) ? NUMBER_OF_CHANNEL
                                                                 : NUMBER_OF_KERNEL,
  localparam int KW     = (NUMBER_OF_KERNEL > 1) ? $clog2(NUMBER_OF_KERNEL) : 1,
  localparam int CW     = (MAX_CK > 1) ? $clog2(MAX_CK) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_valid,
  output logic          o_valid,
  output logic          o_busy,
  output logic [1:0]    o_layer,
  output logic [KW-1:0] o_kernel_idx,
  output logic [CW-1:0] o_channel_idx,
  output logic [15:0]   o_image_width,
  output logic          o_conv_start,
  output logic          o_acc_clear,
  input  logic          i_conv_done,
  output logic          o_kernel_done,
  output logic          o_pool_start,
  input  logic          i_pool_done
);

  // Last legal index of each counter. Layer 0 reads the block's input
  // channels; every later layer reads the previous layer's kernel outputs.
  localparam logic [CW-1:0] CH0_LAST = CW'(NUMBER_OF_CHANNEL - 1);
  localparam logic [CW-1:0] CHN_LAST = CW'(NUMBER_OF_KERNEL - 1);
  localparam logic [KW-1:0] K_LAST   = KW'(NUMBER_OF_KERNEL - 1);
  localparam logic [1:0]    L_LAST   = 2'(NUM_LAYERS - 1);
  localparam logic [15:0]   IMG_W    = 16'(IMAGE_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_CONV,
    S_POOL,
    S_WAIT_POOL,
    S_DONE
  } state_t;

  state_t        state_q;
  logic [1:0]    layer_q;
  logic [KW-1:0] kernel_q;
  logic [CW-1:0] channel_q;
  logic          busy_q;
  logic          valid_q;
  logic          conv_start_q;
  logic          acc_clear_q;
  logic          kernel_done_q;
  logic          pool_start_q;
  logic [15:0]   image_width_q;

  logic chan_last;
  logic kern_last;
  logic layer_last;

  // End-of-range flags for the three nested counters (exact compares, no wrap).
  assign chan_last  = (channel_q == ((layer_q == 2'd0) ? CH0_LAST : CHN_LAST));
  assign kern_last  = (kernel_q == K_LAST);
  assign layer_last = (layer_q == L_LAST);

  // Sequencer FSM: state, loop counters and all registered outputs together.
  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge, so it lives inside the
    // clocked block; all state here is flops (no memories), so all of it
    // can and does get a reset value.
    if (!rst_n) begin
      state_q       <= S_IDLE;
      layer_q       <= '0;
      kernel_q      <= '0;
      channel_q     <= '0;
      busy_q        <= 1'b0;
      valid_q       <= 1'b0;
      conv_start_q  <= 1'b0;
      acc_clear_q   <= 1'b0;
      kernel_done_q <= 1'b0;
      pool_start_q  <= 1'b0;
      image_width_q <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every right-hand side
      // sees the pre-edge value and the pulse defaults below are simply
      // overridden by the later assignments in the case arms.
      conv_start_q  <= 1'b0;
      acc_clear_q   <= 1'b0;
      kernel_done_q <= 1'b0;
      pool_start_q  <= 1'b0;
      valid_q       <= 1'b0;
      image_width_q <= IMG_W;

      unique case (state_q)
        S_IDLE: begin
          if (i_valid) begin
            layer_q      <= '0;
            kernel_q     <= '0;
            channel_q    <= '0;
            state_q      <= S_ISSUE;
            busy_q       <= 1'b1;
            conv_start_q <= 1'b1;
            acc_clear_q  <= 1'b1;
          end
        end

        S_ISSUE: state_q <= S_WAIT_CONV;

        S_WAIT_CONV: begin
          if (i_conv_done) begin
            if (!chan_last) begin
              channel_q    <= channel_q + CW'(1);
              state_q      <= S_ISSUE;
              conv_start_q <= 1'b1;
            end else begin
              kernel_done_q <= 1'b1;
              channel_q     <= '0;
              if (!kern_last) begin
                kernel_q     <= kernel_q + KW'(1);
                state_q      <= S_ISSUE;
                conv_start_q <= 1'b1;
                acc_clear_q  <= 1'b1;
              end else if (!layer_last) begin
                kernel_q     <= '0;
                layer_q      <= layer_q + 2'd1;
                state_q      <= S_ISSUE;
                conv_start_q <= 1'b1;
                acc_clear_q  <= 1'b1;
              end else if (POOL_EN != 0) begin
                state_q      <= S_POOL;
                pool_start_q <= 1'b1;
              end else begin
                state_q <= S_DONE;
              end
            end
          end
        end

        S_POOL: state_q <= S_WAIT_POOL;

        S_WAIT_POOL: begin
          if (i_pool_done) state_q <= S_DONE;
        end

        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          valid_q <= 1'b1;
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_valid       = valid_q;
  assign o_busy        = busy_q;
  assign o_layer       = layer_q;
  assign o_kernel_idx  = kernel_q;
  assign o_channel_idx = channel_q;
  assign o_image_width = image_width_q;
  assign o_conv_start  = conv_start_q;
  assign o_acc_clear   = acc_clear_q;
  assign o_kernel_done = kernel_done_q;
  assign o_pool_start  = pool_start_q;

endmodule

// File: tb/tb_block_nconv_sequencer.sv
// Self-checking bench for block_nconv_sequencer. Three instances cover the
// small two-layer block, the single-job block without pooling, and the
// default configuration. Engine responses use random latencies; expected
// job order, pulse timing and totals come from a nested-loop job list.
module tb_block_nconv_sequencer;

  localparam int IW_A   = 28;
  localparam int IW_B   = 14;
  localparam int IW_C   = 56;
  localparam int BUDGET = 5000;

  typedef struct packed {
    int l;
    int k;
    int c;
  } job_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [2:0]       v_i, cd_i, pd_i;
  logic [2:0]       valid_o, busy_o, cs_o, clr_o, kd_o, ps_o;
  logic [2:0][1:0]  layer_o;
  logic [2:0][15:0] iw_o;
  logic [2:0][3:0]  kidx_o, cidx_o;
  logic [0:0]       kidx_a, kidx_b, cidx_b;
  logic [1:0]       cidx_a;
  logic [3:0]       kidx_c, cidx_c;

  assign kidx_o[0] = {3'b000, kidx_a};
  assign cidx_o[0] = {2'b00, cidx_a};
  assign kidx_o[1] = {3'b000, kidx_b};
  assign cidx_o[1] = {3'b000, cidx_b};
  assign kidx_o[2] = kidx_c;
  assign cidx_o[2] = cidx_c;

  int total_checks  = 0;
  int passed_checks = 0;
  int seen_clear[$];
  int seen_chan[$];

  // Instance 0: L=2, K=2, C=3, pooling on.
  block_nconv_sequencer #(
    .NUM_LAYERS(2), .IMAGE_WIDTH(IW_A), .NUMBER_OF_KERNEL(2),
    .NUMBER_OF_CHANNEL(3), .POOL_EN(1)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .i_valid(v_i[0]), .o_valid(valid_o[0]),
    .o_busy(busy_o[0]), .o_layer(layer_o[0]), .o_kernel_idx(kidx_a),
    .o_channel_idx(cidx_a), .o_image_width(iw_o[0]), .o_conv_start(cs_o[0]),
    .o_acc_clear(clr_o[0]), .i_conv_done(cd_i[0]), .o_kernel_done(kd_o[0]),
    .o_pool_start(ps_o[0]), .i_pool_done(pd_i[0])
  );

  // Instance 1: L=1, K=1, C=1, pooling off.
  block_nconv_sequencer #(
    .NUM_LAYERS(1), .IMAGE_WIDTH(IW_B), .NUMBER_OF_KERNEL(1),
    .NUMBER_OF_CHANNEL(1), .POOL_EN(0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .i_valid(v_i[1]), .o_valid(valid_o[1]),
    .o_busy(busy_o[1]), .o_layer(layer_o[1]), .o_kernel_idx(kidx_b),
    .o_channel_idx(cidx_b), .o_image_width(iw_o[1]), .o_conv_start(cs_o[1]),
    .o_acc_clear(clr_o[1]), .i_conv_done(cd_i[1]), .o_kernel_done(kd_o[1]),
    .o_pool_start(ps_o[1]), .i_pool_done(pd_i[1])
  );

  // Instance 2: default parameters.
  block_nconv_sequencer dut_c (
    .clk(clk), .rst_n(rst_n), .i_valid(v_i[2]), .o_valid(valid_o[2]),
    .o_busy(busy_o[2]), .o_layer(layer_o[2]), .o_kernel_idx(kidx_c),
    .o_channel_idx(cidx_c), .o_image_width(iw_o[2]), .o_conv_start(cs_o[2]),
    .o_acc_clear(clr_o[2]), .i_conv_done(cd_i[2]), .o_kernel_done(kd_o[2]),
    .o_pool_start(ps_o[2]), .i_pool_done(pd_i[2])
  );

  // Drives one block run on instance sel, acting as conv and pool engine,
  // and checks every job and pulse against the expected job list.
  task automatic run_block(input int sel, input int nl, input int nk, input int nc,
                           input int pen, input int dmin, input int dmax,
                           input bit hold_valid, input bit spurious, input int abort_job,
                           output int n_conv, output int n_kd, output int n_pool,
                           output int n_valid);
    job_t exp_q[$];
    job_t cur;
    int   j, done_at, last_done, pool_start_at, pool_done_at, valid_at, want;
    bit   last_ch, safe_cd, safe_pd;
    for (int l = 0; l < nl; l++)
      for (int k = 0; k < nk; k++)
        for (int c = 0; c < ((l == 0) ? nc : nk); c++) begin
          cur.l = l; cur.k = k; cur.c = c;
          exp_q.push_back(cur);
        end
    n_conv = 0; n_kd = 0; n_pool = 0; n_valid = 0;
    j = 0; done_at = -1; last_done = -100; last_ch = 1'b0;
    pool_start_at = -1; pool_done_at = -1; valid_at = -1;
    cur = '0;
    seen_clear.delete();
    seen_chan.delete();
    for (int m = 0; m < BUDGET; m++) begin
      @(negedge clk);
      if (cs_o[sel]) begin
        total_checks++;
        if (j >= exp_q.size()) begin
          $display("FAIL extra_conv_start: dut %0d job %0d, at most %0d jobs expected",
                   sel, j + 1, exp_q.size());
        end else begin
          passed_checks++;
          cur  = exp_q[j];
          want = (j == 0) ? 1 : last_done + 1;
          total_checks++;
          if (m !== want)
            $display("FAIL issue_cycle: dut %0d job %0d got cycle %0d, want %0d", sel, j + 1, m, want);
          else passed_checks++;
          total_checks++;
          if (int'(layer_o[sel]) !== cur.l || int'(kidx_o[sel]) !== cur.k || int'(cidx_o[sel]) !== cur.c)
            $display("FAIL job_index: dut %0d job %0d got l%0d k%0d c%0d, want l%0d k%0d c%0d",
                     sel, j + 1, layer_o[sel], kidx_o[sel], cidx_o[sel], cur.l, cur.k, cur.c);
          else passed_checks++;
          total_checks++;
          if (clr_o[sel] !== (cur.c == 0) || busy_o[sel] !== 1'b1)
            $display("FAIL acc_clear_busy: dut %0d job %0d got clr %b busy %b, want clr %b busy 1",
                     sel, j + 1, clr_o[sel], busy_o[sel], cur.c == 0);
          else passed_checks++;
          seen_chan.push_back(int'(cidx_o[sel]));
          if (clr_o[sel]) seen_clear.push_back(j + 1);
          done_at = m + int'($urandom_range(dmax, dmin));
          j++;
          n_conv++;
          if (j == abort_job) begin
            v_i[sel] = 1'b0; cd_i[sel] = 1'b0; pd_i[sel] = 1'b0;
            return;
          end
        end
      end else if (clr_o[sel]) begin
        total_checks++;
        $display("FAIL stray_acc_clear: dut %0d cycle %0d got clr 1 without conv_start, want 0", sel, m);
      end
      if (kd_o[sel]) begin
        n_kd++;
        total_checks++;
        if (m !== last_done + 1 || !last_ch)
          $display("FAIL kernel_done_timing: dut %0d got cycle %0d (last_ch %b), want %0d after last channel",
                   sel, m, last_ch, last_done + 1);
        else passed_checks++;
      end
      if (ps_o[sel]) begin
        n_pool++;
        pool_start_at = m;
        pool_done_at  = m + int'($urandom_range(3, 1));
        total_checks++;
        if (pen == 0 || j != exp_q.size() || m != last_done + 1 || busy_o[sel] !== 1'b1)
          $display("FAIL pool_start_timing: dut %0d got cycle %0d after %0d jobs, want cycle %0d after %0d jobs",
                   sel, m, j, last_done + 1, exp_q.size());
        else passed_checks++;
      end
      if (valid_o[sel]) begin
        n_valid++;
        want = ((pen != 0) ? pool_done_at : last_done) + 2;
        total_checks++;
        if (m !== want || busy_o[sel] !== 1'b0)
          $display("FAIL valid_timing: dut %0d got cycle %0d busy %b, want cycle %0d busy 0",
                   sel, m, busy_o[sel], want);
        else passed_checks++;
        if (valid_at < 0) valid_at = m;
      end

      v_i[sel] = hold_valid ? (valid_at < 0) : (m == 0);
      if (m == done_at) begin
        last_done = m;
        last_ch   = (cur.c == ((cur.l == 0) ? nc : nk) - 1);
        total_checks++;
        if (int'(layer_o[sel]) !== cur.l || int'(kidx_o[sel]) !== cur.k || int'(cidx_o[sel]) !== cur.c)
          $display("FAIL index_stable: dut %0d at done got l%0d k%0d c%0d, want l%0d k%0d c%0d",
                   sel, layer_o[sel], kidx_o[sel], cidx_o[sel], cur.l, cur.k, cur.c);
        else passed_checks++;
        cd_i[sel] = 1'b1;
      end else begin
        safe_cd   = (m == 0) || cs_o[sel] || (j == exp_q.size() && done_at < m) || (valid_at >= 0);
        cd_i[sel] = spurious && safe_cd && ($urandom_range(1, 0) == 1);
      end
      if (m == pool_done_at) begin
        pd_i[sel] = 1'b1;
      end else begin
        safe_pd   = (pool_start_at < 0) || (m == pool_start_at) || (valid_at >= 0);
        pd_i[sel] = spurious && safe_pd && ($urandom_range(1, 0) == 1);
      end
      if (valid_at >= 0 && m >= valid_at + 4) break;
    end
    v_i[sel] = 1'b0; cd_i[sel] = 1'b0; pd_i[sel] = 1'b0;
    total_checks++;
    if (valid_at < 0)
      $display("FAIL run_timeout: dut %0d got no o_valid within %0d cycles, want one", sel, BUDGET);
    else passed_checks++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; v_i = '1; cd_i = '1; pd_i = '1;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      total_checks++;
      if ({valid_o[s], busy_o[s], cs_o[s], clr_o[s], kd_o[s], ps_o[s]} !== 6'b0 ||
          layer_o[s] !== 2'd0 || kidx_o[s] !== 4'd0 || cidx_o[s] !== 4'd0 || iw_o[s] !== 16'd0)
        $display("FAIL reset_outputs: dut %0d got pulses %b%b%b%b%b%b l%0d k%0d c%0d w%0d, want all 0",
                 s, valid_o[s], busy_o[s], cs_o[s], clr_o[s], kd_o[s], ps_o[s],
                 layer_o[s], kidx_o[s], cidx_o[s], iw_o[s]);
      else passed_checks++;
    end
    v_i = '0; cd_i = '0; pd_i = '0; rst_n = 1'b1;
    @(negedge clk);
    total_checks++;
    if (iw_o[0] !== 16'(IW_A) || iw_o[1] !== 16'(IW_B) || iw_o[2] !== 16'(IW_C) || busy_o !== 3'b000)
      $display("FAIL image_width: got %0d %0d %0d busy %b, want %0d %0d %0d busy 000",
               iw_o[0], iw_o[1], iw_o[2], busy_o, IW_A, IW_B, IW_C);
    else passed_checks++;
  endtask

  task automatic test_two_layer_counts();
    int nc, nk, np, nv;
    run_block(0, 2, 2, 3, 1, 2, 2, 1'b0, 1'b0, 0, nc, nk, np, nv);
    total_checks++;
    if (nc !== 10 || nk !== 4 || np !== 1 || nv !== 1)
      $display("FAIL two_layer_counts: got conv %0d kd %0d pool %0d valid %0d, want 10 4 1 1", nc, nk, np, nv);
    else passed_checks++;
  endtask

  task automatic test_acc_clear_sequence();
    int nc, nk, np, nv, got;
    int exp_clr[4] = '{1, 4, 7, 9};
    int exp_ch[10] = '{0, 1, 2, 0, 1, 2, 0, 1, 0, 1};
    run_block(0, 2, 2, 3, 1, 2, 2, 1'b0, 1'b0, 0, nc, nk, np, nv);
    total_checks++;
    if (seen_clear.size() !== 4 || seen_chan.size() !== 10)
      $display("FAIL seq_lengths: got clears %0d chans %0d, want 4 10", seen_clear.size(), seen_chan.size());
    else passed_checks++;
    for (int i = 0; i < 4; i++) begin
      got = (i < seen_clear.size()) ? seen_clear[i] : -1;
      total_checks++;
      if (got !== exp_clr[i]) $display("FAIL acc_clear_job: entry %0d got job %0d, want %0d", i, got, exp_clr[i]);
      else passed_checks++;
    end
    for (int i = 0; i < 10; i++) begin
      got = (i < seen_chan.size()) ? seen_chan[i] : -1;
      total_checks++;
      if (got !== exp_ch[i]) $display("FAIL channel_seq: job %0d got %0d, want %0d", i + 1, got, exp_ch[i]);
      else passed_checks++;
    end
  endtask

  task automatic test_single_job();
    int nc, nk, np, nv;
    run_block(1, 1, 1, 1, 0, 1, 1, 1'b0, 1'b0, 0, nc, nk, np, nv);
    total_checks++;
    if (nc !== 1 || nk !== 1 || np !== 0 || nv !== 1)
      $display("FAIL single_job_counts: got conv %0d kd %0d pool %0d valid %0d, want 1 1 0 1", nc, nk, np, nv);
    else passed_checks++;
  endtask

  task automatic test_hold_valid();
    int nc, nk, np, nv;
    run_block(0, 2, 2, 3, 1, 1, 3, 1'b1, 1'b1, 0, nc, nk, np, nv);
    total_checks++;
    if (nc !== 10 || nk !== 4 || np !== 1 || nv !== 1)
      $display("FAIL hold_valid_counts: got conv %0d kd %0d pool %0d valid %0d, want 10 4 1 1", nc, nk, np, nv);
    else passed_checks++;
  endtask

  task automatic test_reset_mid();
    int nc, nk, np, nv;
    run_block(0, 2, 2, 3, 1, 2, 3, 1'b0, 1'b0, 5, nc, nk, np, nv);
    @(negedge clk);
    total_checks++;
    if (busy_o[0] !== 1'b1 || cs_o[0] !== 1'b0)
      $display("FAIL wait_conv_state: got busy %b start %b, want busy 1 start 0", busy_o[0], cs_o[0]);
    else passed_checks++;
    rst_n = 1'b0; cd_i[0] = 1'b1;
    @(negedge clk);
    total_checks++;
    if ({valid_o[0], busy_o[0], cs_o[0], clr_o[0], kd_o[0], ps_o[0]} !== 6'b0 ||
        layer_o[0] !== 2'd0 || kidx_o[0] !== 4'd0 || cidx_o[0] !== 4'd0 || iw_o[0] !== 16'd0)
      $display("FAIL mid_reset_outputs: got pulses %b%b%b%b%b%b l%0d k%0d c%0d w%0d, want all 0",
               valid_o[0], busy_o[0], cs_o[0], clr_o[0], kd_o[0], ps_o[0],
               layer_o[0], kidx_o[0], cidx_o[0], iw_o[0]);
    else passed_checks++;
    rst_n = 1'b1; cd_i[0] = 1'b0;
    repeat (2) @(negedge clk);
    total_checks++;
    if ({valid_o[0], busy_o[0], cs_o[0], kd_o[0], ps_o[0]} !== 5'b0)
      $display("FAIL trailing_pulse: got valid %b busy %b start %b kd %b pool %b, want all 0",
               valid_o[0], busy_o[0], cs_o[0], kd_o[0], ps_o[0]);
    else passed_checks++;
    run_block(0, 2, 2, 3, 1, 1, 3, 1'b0, 1'b0, 0, nc, nk, np, nv);
    total_checks++;
    if (nc !== 10 || nk !== 4 || np !== 1 || nv !== 1)
      $display("FAIL rerun_counts: got conv %0d kd %0d pool %0d valid %0d, want 10 4 1 1", nc, nk, np, nv);
    else passed_checks++;
  endtask

  task automatic test_defaults();
    int nc, nk, np, nv;
    run_block(2, 2, 16, 8, 1, 1, 3, 1'b0, 1'b1, 0, nc, nk, np, nv);
    total_checks++;
    if (nc !== 16 * 8 + 16 * 16 || nk !== 2 * 16 || np !== 1 || nv !== 1)
      $display("FAIL default_counts: got conv %0d kd %0d pool %0d valid %0d, want 384 32 1 1", nc, nk, np, nv);
    else passed_checks++;
  endtask

  initial begin
    rst_n = 1'b0; v_i = '0; cd_i = '0; pd_i = '0;
    test_reset();
    test_two_layer_counts();
    test_acc_clear_sequence();
    test_single_job();
    test_hold_valid();
    test_reset_mid();
    test_defaults();
    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
